// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the requester handshakes (instruction fetch and data
//            memory), the shared memory port and the datapath mux select
//            used by mem_port_arbiter.
// Modports : slave  - arbiter side (takes requests and mem_rdata, drives
//                     grants, done pulses, read data, memory command, sel)
//            master - requester/memory side (the mirror image)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
   // instruction fetch requester
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_done;
   logic [31:0] if_rdata;
   // data memory requester
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_done;
   logic [31:0] dm_rdata;
   // shared memory port
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   // datapath address/data mux select: 0 = IF, 1 = DM
   logic        sel;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, sel
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, sel
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates the single shared 32-bit memory port between the
//            instruction-fetch (IF) and data-memory (DM) requesters, drives
//            the datapath mux select, times the fixed-latency access and
//            returns read data with a one-cycle done pulse.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - mem_port_arbiter_if.slave (requests, grants, done
//                    pulses, read data, memory command, sel)
// Params   : MEM_LAT - command-to-read-data latency in cycles (1..7)
// Macro    : ARB_ROUND_ROBIN_EN - when defined, conflicts alternate between
//            requesters; otherwise DM always wins a conflict.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mem_port_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] c_LAT_INIT = 3'(MEM_LAT);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_cnt;
   logic        r_sel;        // current/last winner, 1 = DM
   logic        r_is_store;   // current access is a DM store
   logic        r_mem_we;     // high only during the ISSUE of a store
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_if_rdata;
   logic [31:0] r_dm_rdata;

   logic        w_arb;        // arbitration edge that grants
   logic        w_pick_dm;    // winner of this arbitration, 1 = DM
   logic        w_cap;        // read data is valid on this edge

`ifdef ARB_ROUND_ROBIN_EN
   logic        r_last_dm;    // last winner, 1 = DM
   logic        w_both;

   // on a conflict the requester that did not win last time gets the port
   always_comb begin
      w_both    = bus.if_req & bus.dm_req;
      w_pick_dm = w_both ? ~r_last_dm : bus.dm_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_dm <= 1'b1;
      end else if (w_arb) begin
         r_last_dm <= w_pick_dm;
      end
   end
`else
   // fixed priority: DM wins every conflict
   always_comb begin
      w_pick_dm = bus.dm_req;
   end
`endif

   // ------------------------------------------------------------------
   // state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // next state; arbitration happens in IDLE and in DONE so a pending
   // request is issued in the cycle right after the completion pulse
   // ------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      w_arb  = 1'b0;
      w_cap  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.if_req | bus.dm_req) begin
               w_arb  = 1'b1;
               w_next = S_ISSUE;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_ISSUE: begin
            w_next = S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == 3'd1) begin
               w_cap  = 1'b1;
               w_next = S_DONE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= 3'd0;
         r_sel      <= 1'b0;
         r_is_store <= 1'b0;
         r_mem_we   <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_if_rdata <= 32'd0;
         r_dm_rdata <= 32'd0;
      end else begin
         // write enable is only ever high for the one ISSUE cycle
         r_mem_we <= 1'b0;

         if (w_arb) begin
            r_sel      <= w_pick_dm;
            r_is_store <= w_pick_dm & bus.dm_we;
            r_mem_we   <= w_pick_dm & bus.dm_we;
            r_addr     <= w_pick_dm ? bus.dm_addr : bus.if_addr;
            if (w_pick_dm) begin
               r_wdata <= bus.dm_wdata;
            end
         end

         if (r_state == S_ISSUE) begin
            r_cnt <= c_LAT_INIT;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 3'd1;
         end

         // stores complete without touching dm_rdata
         if (w_cap && !r_is_store) begin
            if (r_sel) begin
               r_dm_rdata <= bus.mem_rdata;
            end else begin
               r_if_rdata <= bus.mem_rdata;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // outputs; strobes decode straight from the state register so an
   // asynchronous reset clears them immediately
   // ------------------------------------------------------------------
   assign bus.mem_en    = (r_state == S_ISSUE);
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.sel       = r_sel;
   assign bus.if_gnt    = (r_state == S_ISSUE) & ~r_sel;
   assign bus.dm_gnt    = (r_state == S_ISSUE) &  r_sel;
   assign bus.if_done   = (r_state == S_DONE)  & ~r_sel;
   assign bus.dm_done   = (r_state == S_DONE)  &  r_sel;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_rdata  = r_dm_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter. Instance a
//            uses MEM_LAT=2, instance b uses MEM_LAT=1. Conflict
//            expectations follow ARB_ROUND_ROBIN_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   mem_port_arbiter_if a ();
   mem_port_arbiter_if b ();

   mem_port_arbiter #(.MEM_LAT(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
   mem_port_arbiter #(.MEM_LAT(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic rr;

   initial begin
`ifdef ARB_ROUND_ROBIN_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      a.if_req = 0; a.if_addr = 0; a.dm_req = 0; a.dm_we = 0;
      a.dm_addr = 0; a.dm_wdata = 0; a.mem_rdata = 0;
      b.if_req = 0; b.if_addr = 0; b.dm_req = 0; b.dm_we = 0;
      b.dm_addr = 0; b.dm_wdata = 0; b.mem_rdata = 0;

      // ---------------- reset state ----------------
      tick(); tick();
      chk("rst_mem_en",   32'(a.mem_en),  0);
      chk("rst_sel",      32'(a.sel),     0);
      chk("rst_gnt",      32'({a.if_gnt, a.dm_gnt}), 0);
      chk("rst_done",     32'({a.if_done, a.dm_done}), 0);
      chk("rst_mem_addr", a.mem_addr,  0);
      chk("rst_if_rdata", a.if_rdata,  0);
      chk("rst_dm_rdata", a.dm_rdata,  0);
      rst_n = 1'b1;
      tick();

      // ---------------- single fetch, LAT=2 ----------------
      a.if_req = 1; a.if_addr = 32'h40; a.mem_rdata = 32'h8C220004;
      tick();                                           // cycle 1
      chk("f_if_gnt",   32'(a.if_gnt), 1);
      chk("f_dm_gnt",   32'(a.dm_gnt), 0);
      chk("f_mem_en",   32'(a.mem_en), 1);
      chk("f_mem_we",   32'(a.mem_we), 0);
      chk("f_sel",      32'(a.sel),    0);
      chk("f_mem_addr", a.mem_addr, 32'h40);
      a.if_req = 0; a.if_addr = 32'hDEAD;
      tick();                                           // cycle 2
      chk("f_c2_gnt",   32'(a.if_gnt), 0);
      chk("f_c2_en",    32'(a.mem_en), 0);
      chk("f_c2_addr",  a.mem_addr, 32'h40);
      tick();                                           // cycle 3
      chk("f_c3_done",  32'(a.if_done), 0);
      tick();                                           // cycle 4
      chk("f_if_done",  32'(a.if_done), 1);
      chk("f_if_rdata", a.if_rdata, 32'h8C220004);
      chk("f_c4_sel",   32'(a.sel), 0);
      tick();                                           // idle
      chk("f_c5_done",  32'(a.if_done), 0);

      // ---------------- DM store ----------------
      a.dm_req = 1; a.dm_we = 1; a.dm_addr = 32'h100; a.dm_wdata = 32'h5;
      a.mem_rdata = 32'hFFFF_FFFF;
      tick();                                           // cycle 1
      chk("s_dm_gnt",    32'(a.dm_gnt), 1);
      chk("s_if_gnt",    32'(a.if_gnt), 0);
      chk("s_mem_en",    32'(a.mem_en), 1);
      chk("s_mem_we",    32'(a.mem_we), 1);
      chk("s_mem_wdata", a.mem_wdata, 32'h5);
      chk("s_mem_addr",  a.mem_addr, 32'h100);
      chk("s_sel",       32'(a.sel), 1);
      a.dm_req = 0; a.dm_we = 0; a.dm_wdata = 32'h99;
      tick();                                           // cycle 2
      chk("s_c2_we",     32'(a.mem_we), 0);
      chk("s_c2_wdata",  a.mem_wdata, 32'h5);
      tick();                                           // cycle 3
      chk("s_c3_we",     32'(a.mem_we), 0);
      tick();                                           // cycle 4
      chk("s_dm_done",   32'(a.dm_done), 1);
      chk("s_c4_we",     32'(a.mem_we), 0);
      chk("s_dm_rdata",  a.dm_rdata, 32'h0);
      tick();

      // ---------------- back-to-back DM loads ----------------
      a.dm_req = 1; a.dm_we = 0; a.dm_addr = 32'h200; a.mem_rdata = 32'h9;
      tick();                                           // cycle 1
      chk("b2b_gnt1",    32'(a.dm_gnt), 1);
      chk("b2b_we1",     32'(a.mem_we), 0);
      a.dm_addr = 32'h204;
      tick(); tick();                                   // cycles 2,3
      tick();                                           // cycle 4
      chk("b2b_done1",   32'(a.dm_done), 1);
      chk("b2b_rdata1",  a.dm_rdata, 32'h9);
      a.mem_rdata = 32'h0;
      tick();                                           // cycle 5
      chk("b2b_gnt2",    32'(a.dm_gnt), 1);
      chk("b2b_addr2",   a.mem_addr, 32'h204);
      a.dm_req = 0;
      tick(); tick();                                   // cycles 6,7
      chk("b2b_c7_done", 32'(a.dm_done), 0);
      tick();                                           // cycle 8
      chk("b2b_done2",   32'(a.dm_done), 1);
      chk("b2b_rdata2",  a.dm_rdata, 32'h0);
      tick();

      // ---------------- conflict, both requests held ----------------
      // last winner here is DM, so round-robin starts with IF
      a.if_req = 1; a.if_addr = 32'h40; a.dm_req = 1; a.dm_we = 0;
      a.dm_addr = 32'h300;
      for (int k = 0; k < 3; k++) begin
         tick();                                        // ISSUE
         chk($sformatf("arb%0d_if_gnt", k), 32'(a.if_gnt), 32'(rr & ((k % 2) == 0)));
         chk($sformatf("arb%0d_dm_gnt", k), 32'(a.dm_gnt), 32'(!(rr & ((k % 2) == 0))));
         if (k == 2) begin
            a.if_req = 0; a.dm_req = 0;
         end
         tick(); tick(); tick();                        // WAIT, WAIT, DONE
      end
      tick();

      // ---------------- reset during WAIT ----------------
      a.dm_req = 1; a.dm_we = 0; a.dm_addr = 32'h400; a.mem_rdata = 32'h77;
      tick();                                           // cycle 1
      chk("r_gnt",       32'(a.dm_gnt), 1);
      a.dm_req = 0;
      tick();                                           // cycle 2 (WAIT)
      rst_n = 1'b0;
      #1;
      chk("r_mem_en",    32'(a.mem_en), 0);
      chk("r_sel",       32'(a.sel), 0);
      chk("r_mem_addr",  a.mem_addr, 0);
      chk("r_mem_wdata", a.mem_wdata, 0);
      chk("r_if_rdata",  a.if_rdata, 0);
      chk("r_dm_rdata",  a.dm_rdata, 0);
      tick();
      chk("r_no_done1",  32'({a.if_done, a.dm_done}), 0);
      tick();
      chk("r_no_done2",  32'({a.if_done, a.dm_done}), 0);
      rst_n = 1'b1;
      a.dm_req = 1; a.dm_addr = 32'h500;
      tick();
      chk("r_regrant",   32'(a.dm_gnt), 1);
      chk("r_re_addr",   a.mem_addr, 32'h500);
      a.dm_req = 0;
      tick(); tick(); tick();

      // ---------------- LAT=1 instance ----------------
      // first conflict after reset
      b.if_req = 1; b.if_addr = 32'h8; b.dm_req = 1; b.dm_we = 0;
      b.dm_addr = 32'hC; b.mem_rdata = 32'h1234;
      tick();                                           // cycle 1
      chk("l1_arb_if",   32'(b.if_gnt), 32'(rr));
      chk("l1_arb_dm",   32'(b.dm_gnt), 32'(!rr));
      b.if_req = 0; b.dm_req = 0;
      tick(); tick(); tick();                           // WAIT, DONE, IDLE
      b.dm_req = 1; b.dm_addr = 32'h10; b.mem_rdata = 32'hCAFE0001;
      tick();                                           // cycle 1
      chk("l1_gnt",      32'(b.dm_gnt), 1);
      b.dm_req = 0;
      tick();                                           // cycle 2
      chk("l1_c2_done",  32'(b.dm_done), 0);
      tick();                                           // cycle 3
      chk("l1_done",     32'(b.dm_done), 1);
      chk("l1_rdata",    b.dm_rdata, 32'hCAFE0001);
      tick();
      chk("l1_c4_done",  32'(b.dm_done), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared 32-bit memory port in the multi-cycle MIPS datapath. Instruction fetch (IF) and data memory (DM) requesters compete for the port. The block grants one requester at a time and drives `sel`, the select of the 2-to-1 address/data mux in front of memory. It also times the fixed-latency memory access and returns read data to the winner with a one-cycle done pulse.

## Interface
- `MEM_LAT`, default 2: cycles from memory command to `mem_rdata` valid; legal range 1..7.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held high until `if_gnt`.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  one-cycle pulse; fetch command issued.
- `if_done`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  32  registered fetch data.
- `dm_req`  in  1  data request; held high until `dm_gnt`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  32  data byte address.
- `dm_wdata`  in  32  store data.
- `dm_gnt`  out  1  one-cycle pulse; data command issued.
- `dm_done`  out  1  one-cycle pulse; access complete.
- `dm_rdata`  out  32  registered load data.
- `mem_en`  out  1  memory command strobe.
- `mem_we`  out  1  memory write enable; only valid with `mem_en`.
- `mem_addr`  out  32  latched address of the winner.
- `mem_wdata`  out  32  latched store data.
- `mem_rdata`  in  32  memory read data.
- `sel`  out  1  datapath mux select; 0 = IF, 1 = DM.

## Operation
- States:
  - IDLE: no access in progress; arbitration runs here.
  - ISSUE: command cycle, exactly 1 cycle.
  - WAIT: latency countdown, `MEM_LAT` cycles.
  - DONE: completion pulse, 1 cycle.
- Arbitration runs in IDLE and DONE.
  - If any request is pending, the winner is chosen, and its addr/wdata/we are latched. `sel` is set to the winner and the state moves to ISSUE.
  - If no request is pending, the state is (or returns to) IDLE.
- ISSUE behaviour:
  - `mem_en`=1 for the whole cycle.
  - `mem_we`=1 only for a DM store.
  - The winner's `*_gnt`=1.
  - Next state is WAIT; a 3-bit counter is loaded with `MEM_LAT`.
- WAIT behaviour:
  - The counter decrements each cycle.
  - On the edge where the counter equals 1, the block captures `mem_rdata` into the winner's `*_rdata` (loads and fetches only) and moves to DONE.
- DONE behaviour: the winner's `*_done`=1.
- A store leaves `dm_rdata` unchanged. A store still takes the full latency and produces `dm_done`.
- The requester samples its inputs only at the arbitration edge. After `*_gnt`, the requester may change its inputs freely. A request still high in DONE, after its own `*_gnt`, is treated as a new request.
- `sel`, `mem_addr`, `mem_wdata` and `mem_we` are registered. They hold their values from ISSUE through DONE and keep their last values in IDLE. `mem_we` is forced to 0 outside ISSUE.
- The loser's request stays pending. No output is given to the loser until it wins.

## Timing
- Request high before edge E0 while in IDLE:
  - `*_gnt` and `mem_en` in cycle 1.
  - `mem_rdata` sampled at the end of cycle 1+`MEM_LAT`.
  - `*_done` and valid `*_rdata` in cycle 2+`MEM_LAT`.
- Back-to-back: next ISSUE is the cycle immediately after DONE. Throughput is 1 access per `MEM_LAT`+2 cycles.
- Reset values, applied asynchronously:
  - State IDLE.
  - All strobes 0; `sel`=0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0.
  - Counter 0.
  - Last-winner flag = DM.
- Reset mid-access (in ISSUE or WAIT) aborts the access. No done pulse follows. Requesters must re-request after `rst_n` rises.
- Simultaneous `if_req` and `dm_req`: resolved per Configuration. Exactly one grant is issued per ISSUE.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On a conflict, the requester that did not win last time wins.
  - The last-winner flag updates at each arbitration that grants.
  - After reset, the first conflict grants IF.
- Undefined: fixed priority, DM always wins a conflict. The last-winner flag is not implemented. IF can starve while `dm_req` is held.

## Test plan
- Single fetch, `MEM_LAT`=2, `if_addr`=0x40, memory returns 0x8C220004 -> `if_gnt` in cycle 1, `if_done` in cycle 4, `if_rdata`=0x8C220004, `sel`=0.
- DM store, addr 0x100, wdata 0x5 -> `mem_en`=`mem_we`=1 in cycle 1 with `mem_wdata`=5; `dm_done` in cycle 4; `dm_rdata` unchanged; `mem_we`=0 in cycles 2-4.
- Both requests held continuously:
  - With macro: grants alternate IF, DM, IF, DM, one every 4 cycles.
  - Without macro: DM granted every time, no `if_gnt`.
- Back-to-back DM loads of 9 then 0 -> second `dm_gnt` in the cycle right after the first `dm_done`; `dm_rdata` reads 9, then 0.
- `rst_n` pulled low during WAIT -> all outputs 0 immediately; no `*_done`; a fresh request after release is granted 1 cycle later.
- `MEM_LAT`=1 single load -> `dm_done` in cycle 3 with the correct data.
